// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage register/status inputs and
// the stall/flush/forward/perf outputs of hazard_ctrl_unit.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic [4:0]       Rs1_E;
    logic [4:0]       Rs2_E;
    logic [4:0]       Rd_E;
    logic [1:0]       ResultSrc_E;
    logic             PCSrc_E;
    logic [4:0]       Rd_M;
    logic             RegWrite_M;
    logic             MemReq_M;
    logic             MemReady;
    logic [4:0]       Rd_W;
    logic             RegWrite_W;
    logic             Stall_F;
    logic             Stall_D;
    logic             Stall_E;
    logic             Stall_M;
    logic             Flush_D;
    logic             Flush_E;
    logic             Flush_W;
    logic [1:0]       ForwardA_E;
    logic [1:0]       ForwardB_E;
    logic             MemErr;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;

    // Pipeline side: reports stage contents, receives controls
    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, PCSrc_E,
               Rd_M, RegWrite_M, MemReq_M, MemReady, Rd_W, RegWrite_W,
        input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
               ForwardA_E, ForwardB_E, MemErr, StallCycles, FlushCount
    );

    // Hazard controller side
    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, PCSrc_E,
               Rd_M, RegWrite_M, MemReq_M, MemReady, Rd_W, RegWrite_W,
        output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
               ForwardA_E, ForwardB_E, MemErr, StallCycles, FlushCount
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use
// and branch handling, and a memory-wait FSM with sticky timeout error.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic       lw_stall;
    logic       mem_stall;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;

    // FSM state register, wait counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // FSM next state: RUN -> WAIT on a miss, WAIT -> RUN on ready or ERR on timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (hz.MemReq_M && !hz.MemReady) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_WAIT: begin
                if (hz.MemReady) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Forwarding selects: MEM holds the younger result, so it beats WB; x0 never forwards
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hz.RegWrite_M && hz.Rd_M != 5'd0 && hz.Rd_M == hz.Rs1_E)
            fwd_a = 2'b10;
        else if (hz.RegWrite_W && hz.Rd_W != 5'd0 && hz.Rd_W == hz.Rs1_E)
            fwd_a = 2'b01;
        if (hz.RegWrite_M && hz.Rd_M != 5'd0 && hz.Rd_M == hz.Rs2_E)
            fwd_b = 2'b10;
        else if (hz.RegWrite_W && hz.Rd_W != 5'd0 && hz.Rd_W == hz.Rs2_E)
            fwd_b = 2'b01;
    end

    assign lw_stall  = (hz.ResultSrc_E == 2'b01) && (hz.Rd_E != 5'd0) &&
                       ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
    assign mem_stall = ((state_q == ST_RUN) && hz.MemReq_M && !hz.MemReady) ||
                       ((state_q == ST_WAIT) && !hz.MemReady) ||
                       (state_q == ST_ERR);

    // Stall/flush outputs: reset, then memory freeze, then branch, then load-use
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_stall) begin
            // Whole pipe frozen; a pending branch flush waits until it moves again
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz.PCSrc_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.Stall_F    = stall_f;
    assign hz.Stall_D    = stall_d;
    assign hz.Stall_E    = stall_e;
    assign hz.Stall_M    = stall_m;
    assign hz.Flush_D    = flush_d;
    assign hz.Flush_E    = flush_e;
    assign hz.Flush_W    = flush_w;
    assign hz.ForwardA_E = rst ? fwd_a : 2'b00;
    assign hz.ForwardB_E = rst ? fwd_b : 2'b00;
    assign hz.MemErr     = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counter next values; both wrap naturally at 2^CNT_W
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f || stall_d || stall_e || stall_m)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if ((flush_d || flush_e) && !mem_stall)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallCycles = stall_cnt_q;
    assign hz.FlushCount  = flush_cnt_q;
`else
    assign hz.StallCycles = {CNT_W{1'b0}};
    assign hz.FlushCount  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios then random
// stimulus, checked against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

    hazard_ctrl_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       pcsrc, rwm, rww, memreq, memrdy;
    } stim_t;

    typedef struct {
        logic [3:0]    stall;   // {F,D,E,M}
        logic [2:0]    flush;   // {D,E,W}
        logic [1:0]    fa, fb;
        logic          err;
        logic [CW-1:0] sc, fc;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;

    // Reference state: consecutive stalled memory cycles, sticky error, counters
    int            m_miss = 0;
    bit            m_err  = 1'b0;
    logic [CW-1:0] m_sc   = '0;
    logic [CW-1:0] m_fc   = '0;

    function automatic logic [1:0] fwd(input logic [4:0] rs, input stim_t s);
        if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b1; s.rs1d = 0; s.rs2d = 0; s.rs1e = 0; s.rs2e = 0;
        s.rde = 0; s.rdm = 0; s.rdw = 0; s.rsrc = 0; s.pcsrc = 0;
        s.rwm = 0; s.rww = 0; s.memreq = 0; s.memrdy = 1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   ms, lw;
        @(posedge clk);
        #1;
        rst               = s.rst;
        hz_if.Rs1_D       = s.rs1d;
        hz_if.Rs2_D       = s.rs2d;
        hz_if.Rs1_E       = s.rs1e;
        hz_if.Rs2_E       = s.rs2e;
        hz_if.Rd_E        = s.rde;
        hz_if.ResultSrc_E = s.rsrc;
        hz_if.PCSrc_E     = s.pcsrc;
        hz_if.Rd_M        = s.rdm;
        hz_if.RegWrite_M  = s.rwm;
        hz_if.MemReq_M    = s.memreq;
        hz_if.MemReady    = s.memrdy;
        hz_if.Rd_W        = s.rdw;
        hz_if.RegWrite_W  = s.rww;

        ms = m_err || ((m_miss > 0 || s.memreq) && !s.memrdy);
        lw = s.rsrc == 2'b01 && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
        e.err = m_err;
        e.sc  = m_sc;
        e.fc  = m_fc;
        e.fa  = 2'b00;
        e.fb  = 2'b00;
        if (!s.rst) begin
            e.stall = 4'b0000; e.flush = 3'b111;
        end else begin
            e.fa = fwd(s.rs1e, s);
            e.fb = fwd(s.rs2e, s);
            if (ms)           begin e.stall = 4'b1111; e.flush = 3'b001; end
            else if (s.pcsrc) begin e.stall = 4'b0000; e.flush = 3'b110; end
            else if (lw)      begin e.stall = 4'b1100; e.flush = 3'b010; end
            else              begin e.stall = 4'b0000; e.flush = 3'b000; end
        end
        sb.push_back(e);

        // Clock edge effect on the reference state
        if (!s.rst) begin
            m_miss = 0; m_err = 1'b0; m_sc = '0; m_fc = '0;
        end else begin
`ifdef HAZ_PERF_CNT_EN
            if (e.stall != 0) m_sc = m_sc + 1'b1;
            if (e.flush[2:1] != 0 && !ms) m_fc = m_fc + 1'b1;
`endif
            if (!m_err) begin
                if (ms) begin
                    m_miss++;
                    if (m_miss > int'(TO)) m_err = 1'b1;
                end else begin
                    m_miss = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    endtask

    // Monitor: outputs are valid every cycle, pop one expectation per sample
    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stall", {hz_if.Stall_F, hz_if.Stall_D, hz_if.Stall_E, hz_if.Stall_M}, e.stall);
            chk("flush", {hz_if.Flush_D, hz_if.Flush_E, hz_if.Flush_W}, e.flush);
            chk("fwdA", hz_if.ForwardA_E, e.fa);
            chk("fwdB", hz_if.ForwardB_E, e.fb);
            chk("memerr", hz_if.MemErr, e.err);
            chk("stallcycles", hz_if.StallCycles, e.sc);
            chk("flushcount", hz_if.FlushCount, e.fc);
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        s = idle();
        hz_if.Rs1_D = 0; hz_if.Rs2_D = 0; hz_if.Rs1_E = 0; hz_if.Rs2_E = 0;
        hz_if.Rd_E = 0; hz_if.ResultSrc_E = 0; hz_if.PCSrc_E = 0; hz_if.Rd_M = 0;
        hz_if.RegWrite_M = 0; hz_if.MemReq_M = 0; hz_if.MemReady = 1;
        hz_if.Rd_W = 0; hz_if.RegWrite_W = 0;

        // Reset
        s.rst = 1'b0; step(s); step(s);

        // Forwarding priority and x0
        s = idle(); s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5; s.rs2e = 5; step(s);
        s.rwm = 0; step(s);
        s.rs1e = 0; step(s);

        // Load-use, then load-use with a taken branch
        s = idle(); s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7; step(s);
        s = idle(); step(s);
        s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7; s.pcsrc = 1; step(s);
        s = idle(); step(s);

        // Three-cycle memory wait
        s = idle(); s.memreq = 1; s.memrdy = 0; step(s); step(s); step(s);
        s.memrdy = 1; step(s);
        s = idle(); step(s);

        // Timeout into ERR, then reset out of it
        s = idle(); s.memreq = 1; s.memrdy = 0;
        for (int i = 0; i < 8; i++) step(s);
        s = idle(); step(s); step(s);
        s.rst = 1'b0; step(s);
        s = idle(); step(s);

        // Taken branch during a memory wait
        s = idle(); s.memreq = 1; s.memrdy = 0; s.pcsrc = 1; step(s); step(s);
        s.memrdy = 1; step(s);
        s = idle(); step(s);

        // Perf scenario: 2-cycle load-use plus 3-cycle memory wait
        s = idle(); s.rst = 1'b0; step(s);
        s = idle(); s.rsrc = 2'b01; s.rde = 3; s.rs1d = 3; step(s); step(s);
        s = idle(); s.memreq = 1; s.memrdy = 0; step(s); step(s); step(s);
        s.memrdy = 1; step(s);
        s = idle(); step(s); step(s);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            s.rst    = ($urandom_range(0, 49) != 0);
            s.rs1d   = 5'($urandom_range(0, 7));
            s.rs2d   = 5'($urandom_range(0, 7));
            s.rs1e   = 5'($urandom_range(0, 7));
            s.rs2e   = 5'($urandom_range(0, 7));
            s.rde    = 5'($urandom_range(0, 7));
            s.rdm    = 5'($urandom_range(0, 7));
            s.rdw    = 5'($urandom_range(0, 7));
            s.rsrc   = 2'($urandom_range(0, 3));
            s.pcsrc  = ($urandom_range(0, 3) == 0);
            s.rwm    = 1'($urandom_range(0, 1));
            s.rww    = 1'($urandom_range(0, 1));
            s.memreq = ($urandom_range(0, 2) == 0);
            s.memrdy = ($urandom_range(0, 3) != 0);
            step(s);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
